// File: rtl/seg_scan_mux.sv
// seg_scan_mux -- multiplexed seven-segment display driver.
//
// Scans DIGITS hex digits onto one shared 7-bit segment bus. Each digit owns
// a slot of SLOT_CYCLES clocks. The first BLANK_CYCLES clocks of every slot
// drive nothing, which prevents ghosting at the hand-over between digits.
// New display values are double-buffered. They reach the display only at a
// frame boundary, and data_ack reports that commit.
//
// Optional build macro: SEG_SCAN_LZB_EN enables leading-zero blanking of
// digits 1..DIGITS-1. The blanking is evaluated on the committed display value.
//
// Ports:
//   clk          system clock, rising edge
//   rst          asynchronous reset, active-high
//   data_in      4*DIGITS hex nibbles, digit 0 in [3:0]
//   data_load    one-cycle strobe that captures data_in
//   data_ack     one-cycle pulse, aligned with frame_start, when a value is committed
//   digit_en     per-digit enable, sampled live
//   seginv       inverts seg and dig at the pads (common-anode boards)
//   seg          segments a..g on bits 0..6
//   dig          digit selects; at most one is active at a time
//   frame_start  one-cycle pulse on the first output cycle of each frame
module seg_scan_mux #(
   parameter int DIGITS       = 2,
   parameter int SLOT_CYCLES  = 1024,
   parameter int BLANK_CYCLES = 16
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic [4*DIGITS-1:0]   data_in,
   input  logic                  data_load,
   output logic                  data_ack,
   input  logic [DIGITS-1:0]     digit_en,
   input  logic                  seginv,
   output logic [6:0]            seg,
   output logic [DIGITS-1:0]     dig,
   output logic                  frame_start
);

   localparam int SLOT_W = $clog2(SLOT_CYCLES);
   localparam int IDX_W  = (DIGITS > 1) ? $clog2(DIGITS) : 1;
   localparam logic [SLOT_W-1:0] SLOT_MAX  = SLOT_W'(SLOT_CYCLES - 1);
   localparam logic [SLOT_W-1:0] BLANK_END = SLOT_W'(BLANK_CYCLES);
   localparam logic [IDX_W-1:0]  IDX_MAX   = IDX_W'(DIGITS - 1);

   function automatic logic [6:0] hex_decode(input logic [3:0] nib);
      logic [6:0] s;
      case (nib)
         4'h0: s = 7'h3F;
         4'h1: s = 7'h06;
         4'h2: s = 7'h5B;
         4'h3: s = 7'h4F;
         4'h4: s = 7'h66;
         4'h5: s = 7'h6D;
         4'h6: s = 7'h7D;
         4'h7: s = 7'h07;
         4'h8: s = 7'h7F;
         4'h9: s = 7'h6F;
         4'hA: s = 7'h77;
         4'hB: s = 7'h7C;
         4'hC: s = 7'h39;
         4'hD: s = 7'h5E;
         4'hE: s = 7'h79;
         default: s = 7'h71;
      endcase
      return s;
   endfunction

   logic [SLOT_W-1:0]   slot_cnt;
   logic [IDX_W-1:0]    idx;
   logic                slot_last;
   logic                frame_end;

   logic [4*DIGITS-1:0] disp;
   logic [4*DIGITS-1:0] pend;
   logic                pend_vld;
   logic                commit_p0;

   logic [DIGITS-1:0]   lzb_mask;
   logic [3:0]          nib_cur;
   logic                en_cur;
   logic [DIGITS-1:0]   dig_oh;
   logic                show;

   logic [6:0]          seg_raw_p1;
   logic [DIGITS-1:0]   dig_raw_p1;
   logic                frame_start_p1;
   logic                data_ack_p1;

   assign slot_last = (slot_cnt == SLOT_MAX);
   assign frame_end = slot_last && (idx == IDX_MAX);

   // ---- stage 0: scan counter and display double buffer ----
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         slot_cnt <= '0;
         idx      <= '0;
      end else if (slot_last) begin
         slot_cnt <= '0;
         idx      <= (idx == IDX_MAX) ? '0 : idx + IDX_W'(1);
      end else begin
         slot_cnt <= slot_cnt + SLOT_W'(1);
      end
   end

   // A load on the boundary edge bypasses the pending register. Otherwise
   // the pending value, if any, is committed. commit_p0 delays the ack by one
   // cycle so that it lines up with frame_start of the frame that shows the data.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         disp      <= '0;
         pend      <= '0;
         pend_vld  <= 1'b0;
         commit_p0 <= 1'b0;
      end else begin
         commit_p0 <= 1'b0;
         if (frame_end) begin
            if (data_load) begin
               disp      <= data_in;
               pend_vld  <= 1'b0;
               commit_p0 <= 1'b1;
            end else if (pend_vld) begin
               disp      <= pend;
               pend_vld  <= 1'b0;
               commit_p0 <= 1'b1;
            end
         end else if (data_load) begin
            pend     <= data_in;
            pend_vld <= 1'b1;
         end
      end
   end

`ifdef SEG_SCAN_LZB_EN
   // Digit k>0 is blanked when it and every higher nibble are zero.
   always_comb begin
      logic all_zero;
      all_zero = 1'b1;
      lzb_mask = '0;
      for (int k = DIGITS - 1; k >= 1; k--) begin
         all_zero    = all_zero && (disp[4*k +: 4] == 4'h0);
         lzb_mask[k] = all_zero;
      end
   end
`else
   assign lzb_mask = '0;
`endif

   always_comb begin
      nib_cur = 4'h0;
      en_cur  = 1'b0;
      dig_oh  = '0;
      for (int k = 0; k < DIGITS; k++) begin
         if (idx == IDX_W'(k)) begin
            nib_cur   = disp[4*k +: 4];
            en_cur    = digit_en[k] && !lzb_mask[k];
            dig_oh[k] = 1'b1;
         end
      end
   end

   assign show = (slot_cnt >= BLANK_END) && en_cur;

   // ---- stage 1: registered raw outputs ----
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         seg_raw_p1     <= '0;
         dig_raw_p1     <= '0;
         frame_start_p1 <= 1'b0;
         data_ack_p1    <= 1'b0;
      end else begin
         seg_raw_p1     <= show ? hex_decode(nib_cur) : 7'h00;
         dig_raw_p1     <= show ? dig_oh : '0;
         frame_start_p1 <= (slot_cnt == '0) && (idx == '0);
         data_ack_p1    <= commit_p0;
      end
   end

   assign seg         = seg_raw_p1 ^ {7{seginv}};
   assign dig         = dig_raw_p1 ^ {DIGITS{seginv}};
   assign frame_start = frame_start_p1;
   assign data_ack    = data_ack_p1;

endmodule

// File: tb/tb_seg_scan_mux.sv
// Scoreboard bench for seg_scan_mux (DIGITS=2, SLOT_CYCLES=8, BLANK_CYCLES=2).
// A frame-position reference model pushes one expected output record per
// clock edge. A separate monitor pops each record and compares it with the
// pad outputs on the falling edge.
module tb_seg_scan_mux;
   localparam int D = 2;
   localparam int S = 8;
   localparam int B = 2;
   localparam int F = D * S;

   logic           clk = 1'b0;
   logic           rst;
   logic [4*D-1:0] data_in;
   logic           data_load;
   logic           data_ack;
   logic [D-1:0]   digit_en;
   logic           seginv;
   logic [6:0]     seg;
   logic [D-1:0]   dig;
   logic           frame_start;

   always #5 clk = ~clk;

   seg_scan_mux #(.DIGITS(D), .SLOT_CYCLES(S), .BLANK_CYCLES(B)) dut (
      .clk(clk), .rst(rst), .data_in(data_in), .data_load(data_load),
      .data_ack(data_ack), .digit_en(digit_en), .seginv(seginv),
      .seg(seg), .dig(dig), .frame_start(frame_start)
   );

   typedef struct packed {
      logic [6:0]   seg;
      logic [D-1:0] dig;
      logic         fs;
      logic         ack;
   } exp_t;

   exp_t exp_q[$];

   logic [6:0] hex_tab [16] = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
                                7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71};

   int n_checks = 0;
   int n_pass   = 0;
   int ack_cnt  = 0;

   // reference model state: j = number of post-reset edges seen so far
   int             j;
   logic [4*D-1:0] m_disp;
   logic [4*D-1:0] m_pend;
   bit             m_pvld;
   bit             m_commit;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
   endtask

   task automatic model_reset();
      j        = 0;
      m_disp   = '0;
      m_pend   = '0;
      m_pvld   = 0;
      m_commit = 0;
      exp_q.delete();
   endtask

   // Predicts what the DUT registers on this edge. The frame position comes
   // from the edge count. The display value seen on this edge is the one held
   // before any commit that happens on this same edge.
   task automatic model_step();
      int         pos, k, s;
      bit         shw;
      logic [3:0] nib;
      exp_t       e;
      pos = j % F;
      k   = pos / S;
      s   = pos % S;
      nib = m_disp[4*k +: 4];
      shw = (s >= B) && digit_en[k];
`ifdef SEG_SCAN_LZB_EN
      if (k > 0 && (m_disp >> (4*k)) == 0) shw = 0;
`endif
      e.seg = shw ? hex_tab[nib] : 7'h00;
      e.dig = shw ? D'(1 << k) : '0;
      e.fs  = (pos == 0);
      e.ack = m_commit;
      m_commit = 0;
      if (pos == F - 1) begin
         if (data_load) begin
            m_disp = data_in; m_pvld = 0; m_commit = 1;
         end else if (m_pvld) begin
            m_disp = m_pend; m_pvld = 0; m_commit = 1;
         end
      end else if (data_load) begin
         m_pend = data_in; m_pvld = 1;
      end
      j++;
      exp_q.push_back(e);
   endtask

   task automatic cyc();
      @(posedge clk);
      if (!rst) model_step();
      #1;
   endtask

   task automatic load(input logic [4*D-1:0] v);
      data_in   = v;
      data_load = 1'b1;
      cyc();
      data_load = 1'b0;
   endtask

   // Advance until the next edge falls on frame position p.
   task automatic wait_pos(input int p);
      for (int i = 0; i < F + 1 && (j % F) != p; i++) cyc();
   endtask

   // monitor: pops one expected record per cycle and compares it with the pads
   initial begin
      exp_t e;
      forever begin
         @(negedge clk);
         if (rst) begin
            check("rst_seg", 32'(seg), 32'({7{seginv}}));
            check("rst_dig", 32'(dig), 32'({D{seginv}}));
            check("rst_fs",  32'(frame_start), 32'(0));
            check("rst_ack", 32'(data_ack), 32'(0));
         end else begin
            if (data_ack) ack_cnt++;
            if (exp_q.size() != 0) begin
               e = exp_q.pop_front();
               check("seg", 32'(seg), 32'(e.seg ^ {7{seginv}}));
               check("dig", 32'(dig), 32'(e.dig ^ {D{seginv}}));
               check("frame_start", 32'(frame_start), 32'(e.fs));
               check("data_ack", 32'(data_ack), 32'(e.ack));
            end
         end
      end
   end

   initial begin
      int a0;
      rst       = 1'b1;
      data_in   = '0;
      data_load = 1'b0;
      seginv    = 1'b0;
      digit_en  = '1;
      model_reset();
      repeat (3) cyc();
      rst = 1'b0;
      repeat (2 * F) cyc();

      // single load, then a frame-aligned ack
      load(8'h3A);
      repeat (3 * F) cyc();

      // two loads within one frame coalesce into one ack
      wait_pos(2);
      load(8'h11);
      wait_pos(6);
      a0 = ack_cnt;
      load(8'h22);
      repeat (2 * F) cyc();
      check("coalesce_acks", 32'(ack_cnt - a0), 32'(1));

      // a load on the boundary edge replaces the older pending value
      wait_pos(3);
      a0 = ack_cnt;
      load(8'h44);
      wait_pos(F - 1);
      load(8'h9C);
      repeat (2 * F) cyc();
      check("boundary_acks", 32'(ack_cnt - a0), 32'(1));

      // inverted pads
      seginv = 1'b1;
      load(8'h80);
      repeat (3 * F) cyc();
      seginv = 1'b0;

      // digit 1 disabled
      digit_en = 2'b01;
      repeat (3 * F) cyc();
      digit_en = 2'b11;

      // reset mid-slot with a load pending
      wait_pos(4);
      load(8'h77);
      cyc();
      rst = 1'b1;
      model_reset();
      #1;
      check("midrst_seg", 32'(seg), 32'(0));
      check("midrst_dig", 32'(dig), 32'(0));
      check("midrst_fs",  32'(frame_start), 32'(0));
      check("midrst_ack", 32'(data_ack), 32'(0));
      cyc();
      cyc();
      rst = 1'b0;
      a0 = ack_cnt;
      repeat (2 * F) cyc();
      check("rst_no_ack", 32'(ack_cnt - a0), 32'(0));

      // leading zeros
      load(8'h05);
      repeat (3 * F) cyc();
      load(8'h50);
      repeat (3 * F) cyc();

      // randomized traffic
      for (int i = 0; i < 800; i++) begin
         data_in   = (4*D)'($urandom);
         data_load = ($urandom_range(0, 19) == 0);
         if ($urandom_range(0, 63) == 0) digit_en = D'($urandom);
         if ($urandom_range(0, 99) == 0) seginv = ~seginv;
         cyc();
      end
      data_load = 1'b0;
      repeat (3 * F) cyc();

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end
endmodule
